// File: rtl/period_meter_if.sv
// Event/measurement bundle for period_meter: clear and pulse go in,
// the measured period and its status flags come out.
interface period_meter_if #(
  parameter int WIDTH = 25
);
  logic             clear;
  logic             pulse;
  logic [WIDTH-1:0] period;
  logic             valid;
  logic             locked;
  logic             timeout;

  // Stimulus side: drives clear/pulse, observes the measurement.
  modport master (
    output clear, pulse,
    input  period, valid, locked, timeout
  );

  // Meter side: consumes clear/pulse, produces the measurement.
  modport slave (
    input  clear, pulse,
    output period, valid, locked, timeout
  );
endinterface

// File: rtl/period_meter.sv
// period_meter: measures the spacing in clock cycles between successive
// single-cycle pulses, flags agreement of consecutive periods (locked) and
// raises a sticky timeout when pulses stop arriving.
module period_meter #(
  parameter int WIDTH     = 25,
  parameter int TIMEOUT   = 27000000,
  parameter int TOLERANCE = 0
) (
  input  logic          clock,
  input  logic          reset,
  period_meter_if.slave bus
);

  localparam logic [WIDTH-1:0] TIMEOUT_C = WIDTH'(TIMEOUT);
  localparam logic [WIDTH:0]   TOL_C     = (WIDTH + 1)'(TOLERANCE);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] prev_period;
  logic             have_prev;
  logic [WIDTH-1:0] period_r;
  logic             valid_r;
  logic             locked_r;
  logic             timeout_r;

  logic [WIDTH:0]   diff;
  logic             within_tol;

  // Absolute difference between the running count and the previous period,
  // one bit wider so neither operand order can underflow.
  always_comb begin
    diff = '0;
    if (count >= prev_period) begin
      diff = {1'b0, count} - {1'b0, prev_period};
    end else begin
      diff = {1'b0, prev_period} - {1'b0, count};
    end
    within_tol = (diff <= TOL_C);
  end

  // Measurement FSM; priority is clear > pulse > timeout > increment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      prev_period <= '0;
      have_prev   <= 1'b0;
      period_r    <= '0;
      valid_r     <= 1'b0;
      locked_r    <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (bus.clear) begin
        state       <= IDLE;
        count       <= '0;
        prev_period <= '0;
        have_prev   <= 1'b0;
        period_r    <= '0;
        locked_r    <= 1'b0;
        timeout_r   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.pulse) begin
              state     <= MEASURE;
              count     <= WIDTH'(1);
              have_prev <= 1'b0;
            end
          end
          MEASURE: begin
            if (bus.pulse) begin
              period_r    <= count;
              valid_r     <= 1'b1;
              count       <= WIDTH'(1);
              prev_period <= count;
              have_prev   <= 1'b1;
              // The first period after arming only seeds prev_period.
              if (have_prev) begin
                locked_r <= within_tol;
              end
            end else if (count == TIMEOUT_C) begin
              state     <= IDLE;
              count     <= '0;
              locked_r  <= 1'b0;
              timeout_r <= 1'b1;
            end else begin
              count <= count + WIDTH'(1);
            end
          end
          default: begin
            state <= IDLE;
            count <= '0;
          end
        endcase
      end
    end
  end

  assign bus.period  = period_r;
  assign bus.valid   = valid_r;
  assign bus.locked  = locked_r;
  assign bus.timeout = timeout_r;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: two instances (TIMEOUT=100/TOL=0 and
// TIMEOUT=20/TOL=1) share the same pulse/clear stimulus and are compared
// every cycle against a timestamp-based reference model.
module tb_period_meter;

  localparam int W = 8;

  logic clock;
  logic reset;

  period_meter_if #(.WIDTH(W)) bus_a ();
  period_meter_if #(.WIDTH(W)) bus_b ();

  period_meter #(.WIDTH(W), .TIMEOUT(100), .TOLERANCE(0)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  period_meter #(.WIDTH(W), .TIMEOUT(20), .TOLERANCE(1)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (time %0t)", tag, actual, expected, $time);
    end
  endtask

  // Reference model: tracks the timestamp of the last accepted pulse; the
  // gap to the current cycle is the measured period.
  int to_lim [2] = '{100, 20};
  int tol    [2] = '{0, 1};
  bit m_armed [2];
  int m_last  [2];
  int m_prev  [2];
  bit m_have  [2];
  int m_period[2];
  bit m_valid [2];
  bit m_locked[2];
  bit m_tout  [2];
  int t = 0;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_armed[i] = 0; m_last[i] = 0; m_prev[i] = 0; m_have[i] = 0;
      m_period[i] = 0; m_valid[i] = 0; m_locked[i] = 0; m_tout[i] = 0;
    end
  endtask

  task automatic model_step(input bit p, input bit c);
    int gap;
    int d;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 0;
      if (c) begin
        m_armed[i] = 0; m_prev[i] = 0; m_have[i] = 0;
        m_period[i] = 0; m_locked[i] = 0; m_tout[i] = 0;
      end else if (m_armed[i]) begin
        gap = t - m_last[i];
        if (p) begin
          m_period[i] = gap;
          m_valid[i]  = 1;
          d = gap - m_prev[i];
          if (d < 0) d = -d;
          if (m_have[i]) m_locked[i] = (d <= tol[i]);
          m_prev[i] = gap;
          m_have[i] = 1;
          m_last[i] = t;
        end else if (gap == to_lim[i]) begin
          m_tout[i]   = 1;
          m_locked[i] = 0;
          m_armed[i]  = 0;
        end
      end else if (p) begin
        m_armed[i] = 1;
        m_last[i]  = t;
        m_have[i]  = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("a_period",  int'(bus_a.period),  m_period[0]);
    check("a_valid",   int'(bus_a.valid),   int'(m_valid[0]));
    check("a_locked",  int'(bus_a.locked),  int'(m_locked[0]));
    check("a_timeout", int'(bus_a.timeout), int'(m_tout[0]));
    check("b_period",  int'(bus_b.period),  m_period[1]);
    check("b_valid",   int'(bus_b.valid),   int'(m_valid[1]));
    check("b_locked",  int'(bus_b.locked),  int'(m_locked[1]));
    check("b_timeout", int'(bus_b.timeout), int'(m_tout[1]));
  endtask

  task automatic cyc(input bit p, input bit c);
    bus_a.pulse = p; bus_b.pulse = p;
    bus_a.clear = c; bus_b.clear = c;
    @(posedge clock);
    model_step(p, c);
    #1;
    compare_all();
    t++;
  endtask

  task automatic silence(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0);
  endtask

  task automatic pulse_after(input int n);
    silence(n - 1);
    cyc(1'b1, 1'b0);
  endtask

  initial begin
    int base;
    int gap;
    int kind;
    model_reset();
    reset = 1'b1;
    bus_a.pulse = 0; bus_b.pulse = 0;
    bus_a.clear = 0; bus_b.clear = 0;
    repeat (3) @(posedge clock);
    #1;
    compare_all();
    @(negedge clock);
    reset = 1'b0;

    // Pulses at 0,10,20,30: lock after the second period of 10.
    cyc(1'b1, 1'b0);
    pulse_after(10);
    check("plan_first_period", int'(bus_a.period), 10);
    check("plan_first_unlocked", int'(bus_a.locked), 0);
    pulse_after(10);
    check("plan_lock", int'(bus_a.locked), 1);
    pulse_after(10);

    // Silence long enough for both instances to time out.
    silence(120);
    check("plan_timeout_sticky", int'(bus_b.timeout), 1);
    check("plan_period_kept", int'(bus_b.period), 10);

    // Pulse held high for four cycles from IDLE.
    repeat (4) cyc(1'b1, 1'b0);
    check("plan_held_period", int'(bus_a.period), 1);

    // Spacings 10,10,11,13 for the tolerance instance.
    silence(3);
    cyc(1'b1, 1'b0);
    pulse_after(10); pulse_after(10); pulse_after(11);
    check("plan_tol_hold", int'(bus_b.locked), 1);
    pulse_after(13);
    check("plan_tol_drop", int'(bus_b.locked), 0);
    check("plan_tol_period", int'(bus_b.period), 13);

    // clear together with pulse at count 7.
    silence(6);
    cyc(1'b1, 1'b1);
    check("plan_clear_period", int'(bus_a.period), 0);
    silence(3);
    cyc(1'b1, 1'b0);

    // Asynchronous reset at count 50, observed before the next edge.
    silence(49);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("async_period_zero", int'(bus_a.period), 0);
    #1;
    reset = 1'b0;
    cyc(1'b1, 1'b0);
    pulse_after(8);
    pulse_after(8);
    check("post_reset_period", int'(bus_a.period), 8);

    // Randomized pulse streams with jitter, long gaps and clears.
    base = 10;
    for (int s = 0; s < 160; s++) begin
      if (s % 10 == 0) base = int'($urandom_range(1, 18));
      kind = int'($urandom_range(0, 19));
      if (kind == 0) begin
        cyc(1'($urandom_range(0, 1)), 1'b1);
      end else if (kind == 1) begin
        gap = int'($urandom_range(95, 130));
        pulse_after(gap);
      end else if (kind == 2) begin
        repeat ($urandom_range(2, 5)) cyc(1'b1, 1'b0);
      end else begin
        gap = base + int'($urandom_range(0, 2));
        pulse_after(gap);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
